// File: rtl/dac_serializer_if.sv
// ---------------------------------------------------------------------------
// dac_serializer_if
// Sample-side handshake and DAC pin bundle for dac_serializer.
//
// Signals:
//   sample        [o-1:0]  parallel sample from the modulation stage
//   sample_valid           sample is valid this cycle
//   sample_ready           holding buffer empty; transfer on valid && ready
//   sclk                   serial clock to the DAC (mode 0, idles low)
//   sdo                    serial data, MSB first
//   cs_n                   frame select, active low
//   busy                   serializer active or buffer occupied
//
// Modports:
//   master : sample producer / pin observer
//   slave  : the serializer itself
//
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface dac_serializer_if #(
  parameter int o = 16
);
  logic [o-1:0] sample;
  logic         sample_valid;
  logic         sample_ready;
  logic         sclk;
  logic         sdo;
  logic         cs_n;
  logic         busy;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready,
    input  sclk,
    input  sdo,
    input  cs_n,
    input  busy
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready,
    output sclk,
    output sdo,
    output cs_n,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/dac_serializer.sv
// ---------------------------------------------------------------------------
// dac_serializer
// Accepts one parallel sample per valid/ready handshake into a one-entry
// holding buffer and shifts it MSB-first to an SPI mode-0 audio DAC.
//
// Parameters:
//   o    sample width in bits and bits per frame (>= 2)
//   DIV  clk cycles per sclk half-period (>= 1)
//   GAP  minimum clk cycles cs_n stays high after a frame, LOAD excluded (>= 1)
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  dac_serializer_if.slave: sample/sample_valid in, sample_ready,
//        sclk, sdo, cs_n, busy out
//
// Frame timing with LOAD in cycle t: cs_n low from t+1, bit k on sdo from
// t+1+2k*DIV, its rising sclk edge at t+1+(2k+1)*DIV, cs_n high again at
// t+1+2*o*DIV. Back-to-back period is 2*o*DIV + GAP + 1 cycles.
//
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dac_serializer #(
  parameter int o   = 16,
  parameter int DIV = 2,
  parameter int GAP = 1
) (
  input  logic            clk,
  input  logic            rst,
  dac_serializer_if.slave bus
);

  // Counter widths; a degenerate one-value counter still gets one bit.
  localparam int HW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(o + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [HW-1:0] HC_MAX = HW'(DIV - 1);
  localparam logic [BW-1:0] BC_MAX = BW'(o);
  localparam logic [GW-1:0] GC_MAX = GW'(GAP - 1);

  // Elaboration-time guard on the legal parameter range.
  if (o < 2) begin : g_bad_width
    $error("dac_serializer: o must be >= 2");
  end
  if (DIV < 1) begin : g_bad_div
    $error("dac_serializer: DIV must be >= 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("dac_serializer: GAP must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [o-1:0]    buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic [o-1:0]    shreg_q, shreg_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            sclk_q, sclk_d;
  logic            sdo_q, sdo_d;
  logic            cs_n_q, cs_n_d;

  logic            accept;

  // Ready is forced low during reset so nothing is latched while the
  // datapath is being cleared.
  assign bus.sample_ready = !buf_full_q && !rst;
  assign accept           = bus.sample_valid && bus.sample_ready;
  assign bus.busy         = (state_q != ST_IDLE) || buf_full_q;
  assign bus.sclk         = sclk_q;
  assign bus.sdo          = sdo_q;
  assign bus.cs_n         = cs_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      shreg_q    <= '0;
      hcnt_q     <= '0;
      bcnt_q     <= '0;
      gcnt_q     <= '0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      shreg_q    <= shreg_d;
      hcnt_q     <= hcnt_d;
      bcnt_q     <= bcnt_d;
      gcnt_q     <= gcnt_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      cs_n_q     <= cs_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    shreg_d    = shreg_q;
    hcnt_d     = hcnt_q;
    bcnt_d     = bcnt_q;
    gcnt_d     = gcnt_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    cs_n_d     = cs_n_q;

    // Accept only happens with the buffer empty, and LOAD only with it
    // full, so the two buffer updates below never collide.
    if (accept) begin
      buf_d      = bus.sample;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        if (buf_full_q) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        shreg_d    = buf_q;
        buf_full_d = 1'b0;
        cs_n_d     = 1'b0;
        sdo_d      = buf_q[o-1];
        hcnt_d     = '0;
        bcnt_d     = '0;
        state_d    = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (hcnt_q == HC_MAX) begin
          hcnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: DAC samples the bit currently on sdo.
            sclk_d = 1'b1;
            bcnt_d = bcnt_q + BW'(1);
          end else if (bcnt_q == BC_MAX) begin
            // Falling edge after the last bit closes the frame.
            sclk_d  = 1'b0;
            cs_n_d  = 1'b1;
            sdo_d   = 1'b0;
            gcnt_d  = '0;
            state_d = ST_GAP;
          end else begin
            // Falling edge: present the next bit (shreg[o-2] becomes MSB).
            sclk_d  = 1'b0;
            shreg_d = shreg_q << 1;
            sdo_d   = shreg_q[o-2];
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end

      ST_GAP: begin
        if (gcnt_q == GC_MAX) begin
          gcnt_d  = '0;
          state_d = buf_full_q ? ST_LOAD : ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dac_serializer.sv
// ---------------------------------------------------------------------------
// tb_dac_serializer
// Directed, self-checking bench for dac_serializer. Instance A uses the
// default timing (o=16, DIV=2, GAP=1); instance B uses DIV=1, GAP=3.
// A negedge monitor reassembles each cs_n-low frame from the bits seen on
// rising sclk edges and logs its timing for the checks below.
//
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dac_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_serializer_if #(.o(16)) a_if ();
  dac_serializer_if #(.o(16)) b_if ();

  dac_serializer #(.o(16), .DIV(2), .GAP(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  dac_serializer #(.o(16), .DIV(1), .GAP(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  typedef struct {
    logic [15:0] bits;
    int          rises;
    int          fall;
    int          up;
    int          first_r;
    int          last_r;
  } frame_t;

  typedef struct {
    logic [15:0] word;
    logic [15:0] exp_bits;
    int          exp_rises;
    int          exp_low;
    int          exp_lead;
  } vec_t;

  frame_t fa[$];
  frame_t fb[$];
  frame_t cur [2];
  logic   sclk_p [2] = '{1'b0, 1'b0};
  logic   csn_p  [2] = '{1'b1, 1'b1};
  int     viol   [2] = '{0, 0};
  int     nfall  [2] = '{0, 0};

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame monitor: bits are captured where the DAC would capture them.
  task automatic mon(input int s, input logic sclk, input logic sdo, input logic csn);
    if (csn_p[s] && !csn) begin
      nfall[s]++;
      cur[s].bits    = '0;
      cur[s].rises   = 0;
      cur[s].fall    = cyc;
      cur[s].up      = -1;
      cur[s].first_r = -1;
      cur[s].last_r  = -1;
    end
    if (sclk && !sclk_p[s]) begin
      if (csn) viol[s]++;
      cur[s].bits  = {cur[s].bits[14:0], sdo};
      cur[s].rises = cur[s].rises + 1;
      if (cur[s].first_r < 0) cur[s].first_r = cyc;
      cur[s].last_r = cyc;
    end
    if (!csn_p[s] && csn) begin
      cur[s].up = cyc;
      if (s == 0) fa.push_back(cur[s]);
      else        fb.push_back(cur[s]);
    end
    sclk_p[s] = sclk;
    csn_p[s]  = csn;
  endtask

  always @(negedge clk) begin
    mon(0, a_if.sclk, a_if.sdo, a_if.cs_n);
    mon(1, b_if.sclk, b_if.sdo, b_if.cs_n);
  end

  // Returns #1 after the posedge on which the handshake happened.
  task automatic send(input int s, input logic [15:0] w);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (s == 0) begin a_if.sample = w; a_if.sample_valid = 1'b1; end
    else        begin b_if.sample = w; b_if.sample_valid = 1'b1; end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = (s == 0) ? a_if.sample_ready : b_if.sample_ready;
    end
    if (got) begin @(posedge clk); #1; end
    if (s == 0) a_if.sample_valid = 1'b0;
    else        b_if.sample_valid = 1'b0;
    check("send_ready", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_frames(input int s, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (((s == 0) ? fa.size() : fb.size()) >= n) break;
      @(negedge clk); #1;
    end
    check("frame_count", (s == 0) ? fa.size() : fb.size(), n);
  endtask

  task automatic wait_idle_a();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!a_if.busy) break;
    end
    check("a_idle", {31'd0, a_if.busy}, 32'd0);
  endtask

  vec_t   vt [6];
  frame_t f;
  int     base;
  int     r;
  int     nf;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    vt[0] = '{16'hA5C3, 16'b1010_0101_1100_0011, 16, 64, 2};
    vt[1] = '{16'h0001, 16'b0000_0000_0000_0001, 16, 64, 2};
    vt[2] = '{16'h8000, 16'b1000_0000_0000_0000, 16, 64, 2};
    vt[3] = '{16'h7FFE, 16'b0111_1111_1111_1110, 16, 64, 2};
    vt[4] = '{16'h1234, 16'b0001_0010_0011_0100, 16, 64, 2};
    vt[5] = '{16'hFFFF, 16'b1111_1111_1111_1111, 16, 64, 2};

    a_if.sample       = 16'hFFFF;
    a_if.sample_valid = 1'b1;
    b_if.sample       = 16'h0000;
    b_if.sample_valid = 1'b0;

    // ---------------- reset with valid data offered ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs_n",  {31'd0, a_if.cs_n},         32'd1);
    check("rst_sclk",  {31'd0, a_if.sclk},         32'd0);
    check("rst_sdo",   {31'd0, a_if.sdo},          32'd0);
    check("rst_ready", {31'd0, a_if.sample_ready}, 32'd0);
    check("rst_busy",  {31'd0, a_if.busy},         32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_if.sample_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, a_if.sample_ready}, 32'd1);
    check("post_rst_busy",  {31'd0, a_if.busy},         32'd0);
    repeat (10) @(negedge clk);
    check("post_rst_no_frame", nfall[0], 0);

    // ---------------- single frame, exact timing ----------------
    fa.delete();
    send(0, 16'hA5C3);
    base = cyc;
    for (int c = 0; c <= 68; c++) begin
      @(negedge clk);
      r = cyc - base;
      if (r == 1)  check("load_cs_n_high", {31'd0, a_if.cs_n},         32'd1);
      if (r == 1)  check("load_ready_low", {31'd0, a_if.sample_ready}, 32'd0);
      if (r == 2)  check("ready_after_load", {31'd0, a_if.sample_ready}, 32'd1);
      if (r == 65) check("busy_in_frame", {31'd0, a_if.busy}, 32'd1);
      if (r == 67) check("busy_after_gap", {31'd0, a_if.busy}, 32'd0);
    end
    wait_frames(0, 1, 20);
    if (fa.size() > 0) begin
      f = fa.pop_front();
      check("a5c3_fall",    f.fall - base,    2);
      check("a5c3_up",      f.up - base,      66);
      check("a5c3_first_r", f.first_r - base, 4);
      check("a5c3_last_r",  f.last_r - base,  64);
      check("a5c3_bits",    {16'd0, f.bits},  {16'd0, 16'b1010_0101_1100_0011});
    end
    wait_idle_a();

    // ---------------- table of single frames ----------------
    for (int i = 0; i < 6; i++) begin
      fa.delete();
      send(0, vt[i].word);
      wait_frames(0, 1, 200);
      if (fa.size() > 0) begin
        f = fa.pop_front();
        check("vec_bits",  {16'd0, f.bits}, {16'd0, vt[i].exp_bits});
        check("vec_rises", f.rises,         vt[i].exp_rises);
        check("vec_low",   f.up - f.fall,   vt[i].exp_low);
        check("vec_lead",  f.first_r - f.fall, vt[i].exp_lead);
      end
      wait_idle_a();
    end

    // ---------------- back-to-back ----------------
    fa.delete();
    send(0, 16'h0001);
    @(negedge clk);
    check("b2b_ready_full0", {31'd0, a_if.sample_ready}, 32'd0);
    send(0, 16'h8000);
    @(negedge clk);
    check("b2b_ready_full1", {31'd0, a_if.sample_ready}, 32'd0);
    send(0, 16'h7FFE);
    @(negedge clk);
    check("b2b_ready_full2", {31'd0, a_if.sample_ready}, 32'd0);
    wait_frames(0, 3, 400);
    if (fa.size() == 3) begin
      check("b2b_bits0",   {16'd0, fa[0].bits}, 32'h0001);
      check("b2b_bits1",   {16'd0, fa[1].bits}, 32'h8000);
      check("b2b_bits2",   {16'd0, fa[2].bits}, 32'h7FFE);
      check("b2b_period1", fa[1].fall - fa[0].fall, 66);
      check("b2b_period2", fa[2].fall - fa[1].fall, 66);
    end
    repeat (100) @(negedge clk);
    check("b2b_no_extra", fa.size(), 3);
    wait_idle_a();

    // ---------------- backpressure: only the handshake cycle counts ----------------
    fa.delete();
    send(0, 16'h1111);
    base = cyc;
    send(0, 16'h2222);
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      r = cyc - base;
      if (r >= 10 && r <= 100) begin
        a_if.sample_valid = 1'b1;
        a_if.sample       = 16'hB000 + 16'(r);
      end else begin
        a_if.sample_valid = 1'b0;
      end
    end
    a_if.sample_valid = 1'b0;
    wait_frames(0, 3, 400);
    if (fa.size() >= 3) begin
      check("bp_bits0", {16'd0, fa[0].bits}, 32'h1111);
      check("bp_bits1", {16'd0, fa[1].bits}, 32'h2222);
      check("bp_bits2", {16'd0, fa[2].bits}, 32'hB044);
    end
    repeat (80) @(negedge clk);
    check("bp_no_extra", fa.size(), 3);
    wait_idle_a();

    // ---------------- reset in the middle of a frame ----------------
    fa.delete();
    send(0, 16'h1234);
    send(0, 16'hBEEF);
    for (int i = 0; i < 200; i++) begin
      if (cur[0].rises >= 7) break;
      @(negedge clk); #1;
    end
    check("mid_rise7", cur[0].rises, 7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_cs_n",  {31'd0, a_if.cs_n},         32'd1);
    check("mid_rst_sclk",  {31'd0, a_if.sclk},         32'd0);
    check("mid_rst_busy",  {31'd0, a_if.busy},         32'd0);
    check("mid_rst_ready", {31'd0, a_if.sample_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_ready", {31'd0, a_if.sample_ready}, 32'd1);
    fa.delete();
    nf = nfall[0];
    repeat (150) @(negedge clk);
    check("mid_no_resume", nfall[0] - nf, 0);
    check("mid_cs_n_idle", {31'd0, a_if.cs_n}, 32'd1);
    send(0, 16'h5A5A);
    wait_frames(0, 1, 200);
    if (fa.size() > 0) begin
      f = fa.pop_front();
      check("mid_new_bits", {16'd0, f.bits}, 32'h5A5A);
    end

    // ---------------- DIV=1, GAP=3 instance ----------------
    fb.delete();
    send(1, 16'hFFFF);
    send(1, 16'hFFFF);
    wait_frames(1, 2, 300);
    if (fb.size() >= 2) begin
      check("b_bits",    {16'd0, fb[0].bits}, 32'hFFFF);
      check("b_rises",   fb[0].rises, 16);
      check("b_low",     fb[0].up - fb[0].fall, 32);
      check("b_lead",    fb[0].first_r - fb[0].fall, 1);
      check("b_span",    fb[0].last_r - fb[0].first_r, 30);
      check("b_gap",     fb[1].fall - fb[0].up, 4);
      check("b_period",  fb[1].fall - fb[0].fall, 36);
      check("b_bits1",   {16'd0, fb[1].bits}, 32'hFFFF);
    end

    // ---------------- sclk never high with cs_n high ----------------
    check("a_sclk_viol", viol[0], 0);
    check("b_sclk_viol", viol[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
